lock_ctrl: RTL and testbench

- Downstream consumer of the serial code-pattern detector in the smart lock datapath.
- Takes the detector's single-cycle pattern-match pulse and a user "enter" strobe that closes each entry attempt, and drives the physical unlock actuator.
- Counts failed attempts and enforces a timed lockout after too many failures.
- Raises an alarm if the door is still open when the unlock window expires.

---
 rtl/lock_pkg.sv | 34 +++
 rtl/lock_timer.sv | 27 ++
 rtl/lock_ctrl.sv | 120 ++++++++++++
 tb/tb_lock_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and defaults for the smart-lock actuator controller.
package lock_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'b00,
      ST_UNLOCKED   = 2'b01,
      ST_DOOR_ALARM = 2'b10,
      ST_LOCKOUT    = 2'b11
   } state_e;

   localparam int unsigned UNLOCK_CYCLES_DEF  = 50;
   localparam int unsigned MAX_FAILS_DEF      = 3;
   localparam int unsigned LOCKOUT_CYCLES_DEF = 200;

   typedef struct packed {
      logic unlock;
      logic alarm;
      logic locked_out;
   } outs_t;

   // Moore output decode; anything unexpected drives every output low.
   function automatic outs_t decode_outs(state_e s);
      outs_t o;
      o = '0;
      case (s)
         ST_UNLOCKED:   o.unlock     = 1'b1;
         ST_DOOR_ALARM: o.alarm      = 1'b1;
         ST_LOCKOUT:    o.locked_out = 1'b1;
         default:       o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that parks at zero; shared by the unlock window
// and the lockout period.
module lock_timer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;

   // Load has priority; otherwise count down and hold at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else if (load)
         cnt_q <= load_val;
      else if (cnt_q != '0)
         cnt_q <= cnt_q - CNT_W'(1);
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/lock_ctrl.sv
// Smart-lock controller: turns detector matches and attempt strobes into a
// timed unlock, counts consecutive failures, enforces a timed lockout and
// raises an alarm if the door is still open when the unlock window closes.
module lock_ctrl
   import lock_pkg::*;
#(
   parameter int unsigned UNLOCK_CYCLES  = UNLOCK_CYCLES_DEF,
   parameter int unsigned MAX_FAILS      = MAX_FAILS_DEF,
   parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF,
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned FAIL_W         = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pattern_detect,
   input  logic              attempt_end,
   input  logic              door_closed,
   output logic              unlock,
   output logic              alarm,
   output logic              locked_out,
   output logic [FAIL_W-1:0] fail_count
);

   state_e            state_q;
   outs_t             outs_q;
   logic              match_seen_q;
   logic [FAIL_W-1:0] fail_q;

   logic              success;
   logic              fail_last;
   logic              tmr_load;
   logic [CNT_W-1:0]  tmr_val;
   logic              tmr_zero;

   // Attempt outcome and timer load request, evaluated only while idle.
   always_comb begin
      success   = match_seen_q | pattern_detect;
      fail_last = ((fail_q + FAIL_W'(1)) == FAIL_W'(MAX_FAILS));
      tmr_load  = (state_q == ST_IDLE) && attempt_end && (success || fail_last);
      tmr_val   = success ? CNT_W'(UNLOCK_CYCLES - 1) : CNT_W'(LOCKOUT_CYCLES - 1);
   end

   lock_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   // Main FSM; outputs are registered alongside the state they decode from.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         outs_q       <= '0;
         match_seen_q <= 1'b0;
         fail_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (attempt_end) begin
                  match_seen_q <= 1'b0;
                  if (success) begin
                     state_q <= ST_UNLOCKED;
                     outs_q  <= decode_outs(ST_UNLOCKED);
                     fail_q  <= '0;
                  end else if (fail_last) begin
                     state_q <= ST_LOCKOUT;
                     outs_q  <= decode_outs(ST_LOCKOUT);
                     fail_q  <= FAIL_W'(MAX_FAILS);
                  end else begin
                     fail_q  <= fail_q + FAIL_W'(1);
                  end
               end else if (pattern_detect) begin
                  match_seen_q <= 1'b1;
               end
            end
            ST_UNLOCKED: begin
               match_seen_q <= 1'b0;
               if (tmr_zero) begin
                  if (door_closed) begin
                     state_q <= ST_IDLE;
                     outs_q  <= decode_outs(ST_IDLE);
                  end else begin
                     state_q <= ST_DOOR_ALARM;
                     outs_q  <= decode_outs(ST_DOOR_ALARM);
                  end
               end
            end
            ST_DOOR_ALARM: begin
               match_seen_q <= 1'b0;
               if (door_closed) begin
                  state_q <= ST_IDLE;
                  outs_q  <= decode_outs(ST_IDLE);
               end
            end
            ST_LOCKOUT: begin
               match_seen_q <= 1'b0;
               if (tmr_zero) begin
                  state_q <= ST_IDLE;
                  outs_q  <= decode_outs(ST_IDLE);
                  fail_q  <= '0;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               outs_q       <= '0;
               match_seen_q <= 1'b0;
               fail_q       <= '0;
            end
         endcase
      end
   end

   assign unlock     = outs_q.unlock;
   assign alarm      = outs_q.alarm;
   assign locked_out = outs_q.locked_out;
   assign fail_count = fail_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: a count-based behavioural model checked every cycle,
// plus literal expectations along a directed scenario.
module tb_lock_ctrl;

   localparam int UNLOCK_CYCLES  = 4;
   localparam int MAX_FAILS      = 3;
   localparam int LOCKOUT_CYCLES = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       pattern_detect;
   logic       attempt_end;
   logic       door_closed;
   logic       unlock;
   logic       alarm;
   logic       locked_out;
   logic [1:0] fail_count;

   int vectors     = 0;
   int miscompares = 0;

   // model state: remaining window lengths, alarm flag, failures, sticky match
   int m_unlock_left = 0;
   int m_lock_left   = 0;
   bit m_alarm       = 0;
   int m_fails       = 0;
   bit m_match       = 0;

   lock_ctrl #(
      .UNLOCK_CYCLES  (UNLOCK_CYCLES),
      .MAX_FAILS      (MAX_FAILS),
      .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
      .CNT_W          (16),
      .FAIL_W         (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .pattern_detect (pattern_detect),
      .attempt_end    (attempt_end),
      .door_closed    (door_closed),
      .unlock         (unlock),
      .alarm          (alarm),
      .locked_out     (locked_out),
      .fail_count     (fail_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // behavioural model, advanced on every rising edge
   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_unlock_left = 0; m_lock_left = 0; m_alarm = 0;
            m_fails = 0; m_match = 0;
         end else if (m_unlock_left > 0) begin
            m_unlock_left--;
            if (m_unlock_left == 0 && !door_closed) m_alarm = 1;
         end else if (m_alarm) begin
            if (door_closed) m_alarm = 0;
         end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
         end else if (attempt_end) begin
            if (m_match || pattern_detect) begin
               m_unlock_left = UNLOCK_CYCLES;
               m_fails = 0;
            end else begin
               m_fails++;
               if (m_fails == MAX_FAILS) m_lock_left = LOCKOUT_CYCLES;
            end
            m_match = 0;
         end else if (pattern_detect) begin
            m_match = 1;
         end
      end
   end

   // per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         check("m_unlock",     int'(unlock),     int'(m_unlock_left > 0));
         check("m_alarm",      int'(alarm),      int'(m_alarm));
         check("m_locked_out", int'(locked_out), int'(m_lock_left > 0));
         check("m_fail_count", int'(fail_count), m_fails);
      end
   end

   task automatic pulse_ae(input logic pd);
      attempt_end = 1'b1; pattern_detect = pd;
      @(negedge clk);
      attempt_end = 1'b0; pattern_detect = 1'b0;
   endtask

   task automatic pd_pulse();
      pattern_detect = 1'b1;
      @(negedge clk);
      pattern_detect = 1'b0;
   endtask

   initial begin
      reset = 1'b0; pattern_detect = 1'b0; attempt_end = 1'b0; door_closed = 1'b1;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_unlock", int'(unlock), 0);
      check("rst_alarm",  int'(alarm), 0);
      check("rst_lock",   int'(locked_out), 0);
      check("rst_fails",  int'(fail_count), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // success: match pulse, gap, then attempt_end
      pd_pulse();
      repeat (3) @(negedge clk);
      pulse_ae(1'b0);
      check("succ_unlock_first", int'(unlock), 1);
      for (int i = 1; i < UNLOCK_CYCLES; i++) begin
         @(negedge clk);
         check("succ_unlock_hold", int'(unlock), 1);
      end
      @(negedge clk);
      check("succ_unlock_end", int'(unlock), 0);
      check("succ_fails", int'(fail_count), 0);
      @(negedge clk);

      // same-cycle match and attempt_end
      pulse_ae(1'b1);
      check("same_cycle_unlock", int'(unlock), 1);
      repeat (UNLOCK_CYCLES + 1) @(negedge clk);

      // three failures into lockout
      for (int i = 1; i <= MAX_FAILS; i++) begin
         pulse_ae(1'b0);
         check("lk_fails", int'(fail_count), i);
         check("lk_locked", int'(locked_out), (i == MAX_FAILS) ? 1 : 0);
      end
      repeat (2) @(negedge clk);
      pulse_ae(1'b1);  // ignored in lockout
      check("lk_ignore_unlock", int'(unlock), 0);
      check("lk_ignore_fails", int'(fail_count), MAX_FAILS);
      repeat (LOCKOUT_CYCLES - 4) @(negedge clk);
      check("lk_last_cycle", int'(locked_out), 1);
      @(negedge clk);
      check("lk_released", int'(locked_out), 0);
      check("lk_fails_clr", int'(fail_count), 0);

      // two failures then a matched attempt
      pulse_ae(1'b0);
      pulse_ae(1'b0);
      check("ft_fails2", int'(fail_count), 2);
      pd_pulse();
      pulse_ae(1'b0);
      check("ft_unlock", int'(unlock), 1);
      check("ft_fails0", int'(fail_count), 0);
      repeat (UNLOCK_CYCLES + 1) @(negedge clk);

      // door held open through the window
      door_closed = 1'b0;
      pulse_ae(1'b1);
      repeat (UNLOCK_CYCLES) @(negedge clk);
      check("da_alarm_on", int'(alarm), 1);
      check("da_unlock_off", int'(unlock), 0);
      repeat (2) @(negedge clk);
      pulse_ae(1'b1);  // ignored while alarmed
      check("da_alarm_hold", int'(alarm), 1);
      check("da_no_unlock", int'(unlock), 0);
      door_closed = 1'b1;
      @(negedge clk);
      check("da_alarm_off", int'(alarm), 0);
      @(negedge clk);

      // async reset mid-window, then no stale match
      pulse_ae(1'b1);
      @(negedge clk);
      pattern_detect = 1'b1;
      #2 reset = 1'b1;
      #1 check("ar_unlock_now", int'(unlock), 0);
      @(negedge clk);
      reset = 1'b0; pattern_detect = 1'b0;
      @(negedge clk);
      pulse_ae(1'b0);
      check("ar_stale_unlock", int'(unlock), 0);
      check("ar_stale_fails", int'(fail_count), 1);

      // stale match set in idle is wiped by reset too
      pd_pulse();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      pulse_ae(1'b0);
      check("ar_idle_stale", int'(unlock), 0);
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
